opcode_decoder: RTL and testbench



---
 rtl/opcode_decoder.sv | 92 +++++++++
 tb/tb_opcode_decoder.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/opcode_decoder.sv
// Purpose: registered i281 instruction decoder, upper instruction byte -> 27 control lines (23 one-hot, 3 group, VALID).
// Latency: one core cycle, output is a flop with no combinational path from opcode_in/dec_en.
// Backpressure: none, a new byte is accepted every cycle. Optional macro OPCODE_DEC_HOLD_EN keeps the output on dec_en=0.
module opcode_decoder (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  opcode_in,
    input  logic        dec_en,
    output logic [26:0] opcode_out
);

    logic [3:0]  op;
    logic [1:0]  sub;
    logic [22:0] lines_d;
    logic [26:0] opcode_d;
    logic [26:0] opcode_q;

    // rX (opcode_in[3:2]) is never used. sub only qualifies INPUT, SHIFT and branch opcodes.
    assign op  = opcode_in[7:4];
    assign sub = opcode_in[1:0];

    // One-hot instruction line from the opcode. Every one of the 256 codes maps to exactly one line.
    always_comb begin
        lines_d = '0;
        case (op)
            4'h0: lines_d[0] = 1'b1;
            4'h1: begin
                case (sub)
                    2'b00:   lines_d[1] = 1'b1;
                    2'b01:   lines_d[2] = 1'b1;
                    2'b10:   lines_d[3] = 1'b1;
                    default: lines_d[4] = 1'b1;
                endcase
            end
            4'h2: lines_d[5]  = 1'b1;
            4'h3: lines_d[6]  = 1'b1;
            4'h4: lines_d[7]  = 1'b1;
            4'h5: lines_d[8]  = 1'b1;
            4'h6: lines_d[9]  = 1'b1;
            4'h7: lines_d[10] = 1'b1;
            4'h8: lines_d[11] = 1'b1;
            4'h9: lines_d[12] = 1'b1;
            4'hA: lines_d[13] = 1'b1;
            4'hB: lines_d[14] = 1'b1;
            4'hC: begin
                // Only bit 0 selects the shift direction. Bit 1 is don't-care.
                if (sub[0]) lines_d[16] = 1'b1;
                else        lines_d[15] = 1'b1;
            end
            4'hD: lines_d[17] = 1'b1;
            4'hE: lines_d[18] = 1'b1;
            default: begin
                case (sub)
                    2'b00:   lines_d[19] = 1'b1;
                    2'b01:   lines_d[20] = 1'b1;
                    2'b10:   lines_d[21] = 1'b1;
                    default: lines_d[22] = 1'b1;
                endcase
            end
        endcase
    end

    // Next output: lines plus group flags and VALID on a decode, otherwise cleared or held.
    always_comb begin
        opcode_d = '0;
        if (dec_en) begin
            opcode_d[22:0] = lines_d;
            opcode_d[23]   = |lines_d[4:1];
            opcode_d[24]   = |lines_d[16:15];
            opcode_d[25]   = |lines_d[22:19];
            opcode_d[26]   = 1'b1;
        end else begin
`ifdef OPCODE_DEC_HOLD_EN
            opcode_d = opcode_q;
`else
            opcode_d = '0;
`endif
        end
    end

    // Output register. Reset clears it immediately and discards any pending decode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opcode_q <= '0;
        end else begin
            opcode_q <= opcode_d;
        end
    end

    assign opcode_out = opcode_q;

endmodule

// File: tb/tb_opcode_decoder.sv
// Purpose: self-checking bench for opcode_decoder against an index-arithmetic reference of the i281 bit map.
// Latency: expects each decode one clock after the sampling edge.
// Backpressure: none, stimulus is applied every cycle.
module tb_opcode_decoder;

    logic        clk;
    logic        rst;
    logic [7:0]  opcode_in;
    logic        dec_en;
    logic [26:0] opcode_out;

    int          checks;
    int          passes;
    logic [26:0] exp_q;

    opcode_decoder dut (
        .clk        (clk),
        .rst        (rst),
        .opcode_in  (opcode_in),
        .dec_en     (dec_en),
        .opcode_out (opcode_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: find the instruction's index in the bit map, then derive group flags from index ranges.
    function automatic logic [26:0] ref_dec(input logic [7:0] v);
        int op;
        int s;
        int idx;
        logic [26:0] r;
        op = int'(v[7:4]);
        s  = int'(v[1:0]);
        if (op == 0)       idx = 0;
        else if (op == 1)  idx = 1 + s;
        else if (op <= 11) idx = op + 3;
        else if (op == 12) idx = 15 + (s % 2);
        else if (op == 13) idx = 17;
        else if (op == 14) idx = 18;
        else               idx = 19 + s;
        r      = '0;
        r[idx] = 1'b1;
        r[23]  = (idx >= 1 && idx <= 4);
        r[24]  = (idx == 15 || idx == 16);
        r[25]  = (idx >= 19 && idx <= 22);
        r[26]  = 1'b1;
        return r;
    endfunction

    task automatic check(input string tag, input logic [26:0] obs, input logic [26:0] expv);
        checks++;
        assert (obs === expv) passes++;
        else $error("FAIL %s: got 0x%07h, expected 0x%07h", tag, obs, expv);
    endtask

    // Drive one byte at the falling edge, then sample #1 after the next rising edge.
    task automatic apply(input logic [7:0] v, input logic en);
        @(negedge clk);
        opcode_in = v;
        dec_en    = en;
        @(posedge clk);
        #1;
        if (en) begin
            exp_q = ref_dec(v);
        end else begin
`ifdef OPCODE_DEC_HOLD_EN
            exp_q = exp_q;
`else
            exp_q = '0;
`endif
        end
    endtask

    initial begin
        logic [7:0]  v;
        logic        en;
        logic [26:0] hold_exp;
        checks    = 0;
        passes    = 0;
        exp_q     = '0;
        rst       = 1'b1;
        opcode_in = 8'($urandom);
        dec_en    = 1'b1;

        // Reset held: output stays zero whatever is driven.
        #2;
        check("reset_initial", opcode_out, 27'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            opcode_in = 8'($urandom);
            dec_en    = 1'($urandom);
            @(posedge clk);
            #1;
            check("reset_held", opcode_out, 27'h0);
        end

        // Release between edges: first edge decodes NOOP.
        @(negedge clk);
        rst       = 1'b0;
        opcode_in = 8'h00;
        dec_en    = 1'b1;
        @(posedge clk);
        #1;
        check("first_after_release", opcode_out, 27'h4000001);
        exp_q = 27'h4000001;

        // Directed decodes.
        apply(8'h13, 1'b1);
        check("INPUTDF", opcode_out, 27'h4800010);
        apply(8'hC5, 1'b1);
        check("SHIFTR", opcode_out, 27'h5010000);
        apply(8'hFE, 1'b1);
        check("BRG", opcode_out, 27'h6200000);
        apply(8'h4A, 1'b1);
        check("ADD", opcode_out, 27'h4000080);
        apply(8'h4A, 1'b0);
`ifdef OPCODE_DEC_HOLD_EN
        check("dec_en_low", opcode_out, 27'h4000080);
`else
        check("dec_en_low", opcode_out, 27'h0);
`endif

        // Full sweep, one value per cycle.
        for (int i = 0; i < 256; i++) begin
            apply(8'(i), 1'b1);
            check("sweep", opcode_out, exp_q);
            check("sweep_onehot", 27'($countones(opcode_out[22:0])), 27'd1);
            check("sweep_valid", {26'd0, opcode_out[26]}, 27'd1);
        end

        // Asynchronous reset asserted mid-cycle drops the pending decode.
        apply(8'hFE, 1'b1);
        check("pre_async", opcode_out, 27'h6200000);
        @(negedge clk);
        opcode_in = 8'h13;
        dec_en    = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check("async_clear", opcode_out, 27'h0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check("async_held", opcode_out, 27'h0);
        end
        @(negedge clk);
        rst   = 1'b0;
        exp_q = '0;
        apply(8'h13, 1'b1);
        check("after_async_release", opcode_out, 27'h4800010);

        // Random bytes and enables against the reference.
        for (int i = 0; i < 300; i++) begin
            v  = 8'($urandom);
            en = ($urandom_range(0, 3) != 0);
            hold_exp = exp_q;
            apply(v, en);
            check(en ? "random_dec" : "random_idle", opcode_out, exp_q);
            if (!en) begin
`ifdef OPCODE_DEC_HOLD_EN
                check("random_idle_hold", opcode_out, hold_exp);
`else
                check("random_idle_zero", opcode_out, 27'h0);
`endif
            end
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
